// File: rtl/mem_arbiter_if.sv
// Bundle of the requester handshakes and the shared memory bus seen by mem_arbiter.
// The slave modport is the arbiter's view; master is the core/memory environment.
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;

    logic        err;

    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
        output i_rdata, i_ack, d_rdata, d_ack, err, m_req, m_we, m_addr, m_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
        input  i_rdata, i_ack, d_rdata, d_ack, err, m_req, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data access onto one single-port memory bus.
// Data has priority, limited by a burst counter so fetch cannot starve; stalled accesses time out.
module mem_arbiter #(
    parameter int MAX_D_BURST = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic        clk,
    input  logic        rst,
    mem_arbiter_if.slave bus
);
    localparam int CW = $clog2(MAX_D_BURST + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] D_MAX  = CW'(MAX_D_BURST);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    state_t        state_q,   state_d;
    owner_t        owner_q,   owner_d;
    logic [CW-1:0] d_cnt_q,   d_cnt_d;
    logic [TW-1:0] tcnt_q,    tcnt_d;
    logic          m_req_q,   m_req_d;
    logic          m_we_q,    m_we_d;
    logic [31:0]   m_addr_q,  m_addr_d;
    logic [31:0]   m_wdata_q, m_wdata_d;
    logic [31:0]   i_rdata_q, i_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          i_ack_q,   i_ack_d;
    logic          d_ack_q,   d_ack_d;
    logic          err_q,     err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            d_cnt_q   <= '0;
            tcnt_q    <= '0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            d_cnt_q   <= d_cnt_d;
            tcnt_q    <= tcnt_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        d_cnt_d   = d_cnt_q;
        tcnt_d    = tcnt_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                if (bus.d_req && (!bus.i_req || (d_cnt_q < D_MAX))) begin
                    owner_d   = OWN_D;
                    m_we_d    = bus.d_we;
                    m_addr_d  = bus.d_addr;
                    m_wdata_d = bus.d_wdata;
                    m_req_d   = 1'b1;
                    tcnt_d    = '0;
                    state_d   = BUSY;
                    if (!bus.i_req) begin
                        d_cnt_d = '0;
                    end else if (d_cnt_q != D_MAX) begin
                        d_cnt_d = d_cnt_q + 1'b1;
                    end
                end else if (bus.i_req) begin
                    owner_d   = OWN_I;
                    m_we_d    = 1'b0;
                    m_addr_d  = bus.i_addr;
                    m_wdata_d = '0;
                    m_req_d   = 1'b1;
                    tcnt_d    = '0;
                    d_cnt_d   = '0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                // A memory ack in the final timeout cycle still completes the access normally.
                if (bus.m_ack) begin
                    if (owner_q == OWN_D) begin
                        d_rdata_d = m_we_q ? 32'h0 : bus.m_rdata;
                        d_ack_d   = 1'b1;
                    end else begin
                        i_rdata_d = bus.m_rdata;
                        i_ack_d   = 1'b1;
                    end
                    err_d   = 1'b0;
                    m_req_d = 1'b0;
                    state_d = RESP;
                end else if (tcnt_q == T_LAST) begin
                    if (owner_q == OWN_D) begin
                        d_rdata_d = '0;
                        d_ack_d   = 1'b1;
                    end else begin
                        i_rdata_d = '0;
                        i_ack_d   = 1'b1;
                    end
                    err_d   = 1'b1;
                    m_req_d = 1'b0;
                    state_d = RESP;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            RESP: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.m_req   = m_req_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.i_ack   = i_ack_q;
    assign bus.d_ack   = d_ack_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: table of single transactions against a scripted memory,
// plus hand-written priority/burst and mid-transaction reset sequences.
module tb_mem_arbiter;
    localparam int MAX_D_BURST = 4;
    localparam int TIMEOUT     = 16;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wait_cyc;
        logic        never;
        logic [31:0] mem_data;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_mreq;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .MAX_D_BURST(MAX_D_BURST),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          ack_count = 0;
    exp_t        sb[$];
    logic [31:0] grant_log[$];

    int          mem_wait = 0;
    logic        mem_never = 1'b0;
    logic [31:0] mem_rdata = '0;
    int          mem_cnt = 0;
    int          last_mreq = 0;
    logic        unstable = 1'b0;
    logic [31:0] g_addr = '0;
    logic [31:0] g_wdata = '0;
    logic        g_we = 1'b0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s actual=event expected=none", name);
    endtask

    // Memory model: acks after mem_wait extra cycles and watches the bus stay stable while m_req is high.
    always @(negedge clk) begin
        if (!rst || !bus.m_req) begin
            bus.m_ack = 1'b0;
            if (mem_cnt > 0) last_mreq = mem_cnt;
            mem_cnt = 0;
        end else begin
            if (mem_cnt == 0) begin
                g_addr  = bus.m_addr;
                g_we    = bus.m_we;
                g_wdata = bus.m_wdata;
                grant_log.push_back(bus.m_addr);
            end else if (g_addr !== bus.m_addr || g_we !== bus.m_we || g_wdata !== bus.m_wdata) begin
                unstable = 1'b1;
            end
            bus.m_ack   = !mem_never && (mem_cnt == mem_wait);
            bus.m_rdata = bus.m_ack ? mem_rdata : 32'hBAD0BAD0;
            mem_cnt++;
        end
    end

    always @(negedge clk) begin
        if (rst && (bus.i_ack || bus.d_ack)) begin
            exp_t e;
            ack_count++;
            if (bus.i_ack && bus.d_ack) fail_now("both_acks");
            if (sb.size() == 0) begin
                fail_now("unexpected_ack");
            end else begin
                e = sb.pop_front();
                check_output("ack_port", {31'b0, bus.d_ack}, {31'b0, e.is_d});
                check_output("ack_rdata", e.is_d ? bus.d_rdata : bus.i_rdata, e.rdata);
                check_output("ack_err", {31'b0, bus.err}, {31'b0, e.err});
            end
        end
    end

    task automatic apply_stimulus(input vec_t v);
        int lat;
        bit got;
        lat = 0;
        got = 1'b0;
        @(posedge clk);
        #1;
        mem_wait  = v.wait_cyc;
        mem_never = v.never;
        mem_rdata = v.mem_data;
        unstable  = 1'b0;
        sb.push_back('{v.is_d, v.exp_rdata, v.exp_err});
        if (v.is_d) begin
            bus.d_we    = v.we;
            bus.d_addr  = v.addr;
            bus.d_wdata = v.wdata;
            bus.d_req   = 1'b1;
        end else begin
            bus.i_addr = v.addr;
            bus.i_req  = 1'b1;
        end
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.i_ack || bus.d_ack) begin
                got = 1'b1;
                break;
            end
            lat++;
        end
        if (!got) fail_now("ack_wait_expired");
        else check_output("latency", lat, v.exp_lat);
        check_output("grant_addr", g_addr, v.addr);
        check_output("grant_we", {31'b0, g_we}, {31'b0, v.is_d & v.we});
        check_output("grant_wdata", g_wdata, v.is_d ? v.wdata : 32'h0);
        @(posedge clk);
        #1;
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        @(negedge clk);
        check_output("ack_one_cycle", {30'b0, bus.i_ack, bus.d_ack}, 32'h0);
        check_output("err_cleared", {31'b0, bus.err}, 32'h0);
        check_output("m_req_idle", {31'b0, bus.m_req}, 32'h0);
        check_output("rdata_hold", v.is_d ? bus.d_rdata : bus.i_rdata, v.exp_rdata);
        check_output("mreq_cycles", last_mreq, v.exp_mreq);
        check_output("bus_stable", {31'b0, unstable}, 32'h0);
    endtask

    task automatic check_reset_outputs();
        check_output("rst_i_ack", {31'b0, bus.i_ack}, 32'h0);
        check_output("rst_d_ack", {31'b0, bus.d_ack}, 32'h0);
        check_output("rst_err", {31'b0, bus.err}, 32'h0);
        check_output("rst_i_rdata", bus.i_rdata, 32'h0);
        check_output("rst_d_rdata", bus.d_rdata, 32'h0);
        check_output("rst_m_req", {31'b0, bus.m_req}, 32'h0);
        check_output("rst_m_we", {31'b0, bus.m_we}, 32'h0);
        check_output("rst_m_addr", bus.m_addr, 32'h0);
        check_output("rst_m_wdata", bus.m_wdata, 32'h0);
    endtask

    initial begin
        vec_t vecs[7];
        vec_t post_rst;
        int   start;
        bit   done;

        //         is_d  we    addr          wdata         wait never mem_data      exp_rdata     err   mreq lat
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,        1,  1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2,  3};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_2000, 32'h12345678, 3,  1'b0, 32'hFFFF0000, 32'h0,        1'b0, 4,  5};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_3004, 32'h77777777, 0,  1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1,  2};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_4000, 32'h0,        0,  1'b1, 32'h0,        32'h0,        1'b1, 16, 17};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_4008, 32'h0,        15, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 16, 17};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0,        0,  1'b1, 32'h0,        32'h0,        1'b1, 16, 17};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,        2,  1'b0, 32'h11223344, 32'h11223344, 1'b0, 3,  4};
        post_rst = '{1'b0, 1'b0, 32'h0000_0300, 32'h0,       1,  1'b0, 32'h0BADF00D, 32'h0BADF00D, 1'b0, 2,  3};

        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.m_ack   = 1'b0;
        bus.m_rdata = '0;

        repeat (3) @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b1;

        foreach (vecs[k]) apply_stimulus(vecs[k]);

        // Both requesters held: four data grants, then one fetch, repeating.
        @(posedge clk);
        #1;
        grant_log.delete();
        mem_wait    = 1;
        mem_never   = 1'b0;
        mem_rdata   = 32'h55AA55AA;
        bus.i_addr  = 32'h0000_1000;
        bus.d_addr  = 32'h0000_8000;
        bus.d_we    = 1'b0;
        bus.d_wdata = 32'h0;
        for (int k = 0; k < 10; k++) sb.push_back('{!(k == 4 || k == 9), 32'h55AA55AA, 1'b0});
        start = ack_count;
        done  = 1'b0;
        bus.i_req = 1'b1;
        bus.d_req = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (ack_count == start + 10) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) fail_now("burst_wait_expired");
        @(posedge clk);
        #1;
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        @(negedge clk);
        check_output("burst_grants", grant_log.size(), 10);
        for (int k = 0; k < 10 && k < grant_log.size(); k++) begin
            check_output($sformatf("grant_order_%0d", k), grant_log[k],
                         (k == 4 || k == 9) ? 32'h0000_1000 : 32'h0000_8000);
        end

        // Reset pulled while the memory is stalled: request abandoned, no ack.
        @(posedge clk);
        #1;
        mem_never  = 1'b1;
        bus.i_addr = 32'h0000_0400;
        bus.i_req  = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        check_output("busy_before_reset", {31'b0, bus.m_req}, 32'h1);
        rst = 1'b0;
        #1;
        check_reset_outputs();
        bus.i_req = 1'b0;
        repeat (3) @(negedge clk);
        check_output("no_ack_in_reset", {30'b0, bus.i_ack, bus.d_ack}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        apply_stimulus(post_rst);

        check_output("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end
endmodule
